// File: rtl/riscv_pkg.sv
// ----------------------------------------------------------------------------
// riscv_pkg
// Shared types and constants for the instruction-fetch slice.
//   NOP_INSTR     : canonical RV32I no-op (addi x0, x0, 0) used for bubbles
//   fetch_state_t : fetch request tracker (IDLE / WAIT / DROP)
//   if_id_t       : contents of the IF/ID pipeline register
// ----------------------------------------------------------------------------
package riscv_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        IDLE = 2'd0,   // no request outstanding
        WAIT = 2'd1,   // granted request outstanding, response wanted
        DROP = 2'd2    // granted request outstanding, response to be discarded
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pcplus4;
        logic        valid;
    } if_id_t;

    localparam if_id_t IF_ID_BUBBLE = '{
        instr:   NOP_INSTR,
        pc:      32'h0,
        pcplus4: 32'h0,
        valid:   1'b0
    };

    // Clears the byte-offset bits; instruction addresses are word aligned.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/if_id_reg.sv
// ----------------------------------------------------------------------------
// if_id_reg
// IF/ID pipeline register. Each cycle, in priority order:
//   flush -> bubble, stall -> hold, load -> take i_data, else -> bubble.
// Ports:
//   clk, reset  : clock, asynchronous active-low reset (loads a bubble)
//   i_stall     : hold current contents
//   i_flush     : insert bubble (wins over stall)
//   i_load      : i_data carries a fetched instruction this cycle
//   i_data      : instruction/PC bundle to load
//   o_data      : registered IF/ID contents
// ----------------------------------------------------------------------------
module if_id_reg
    import riscv_pkg::*;
(
    input  logic   clk,
    input  logic   reset,
    input  logic   i_stall,
    input  logic   i_flush,
    input  logic   i_load,
    input  if_id_t i_data,
    output if_id_t o_data
);

    if_id_t r_q;

    // NOTE: sequential state uses non-blocking (<=) so every flop samples
    // pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_q <= IF_ID_BUBBLE;
        end else if (i_flush) begin
            r_q <= IF_ID_BUBBLE;
        end else if (i_stall) begin
            r_q <= r_q;
        end else if (i_load) begin
            r_q <= i_data;
        end else begin
            r_q <= IF_ID_BUBBLE;
        end
    end

    assign o_data = r_q;

endmodule

// File: rtl/fetch_stage.sv
// ----------------------------------------------------------------------------
// fetch_stage
// Instruction fetch: owns PCF, issues single-outstanding requests over a
// req/gnt/rvalid handshake, parks responses that arrive during a decode
// stall, and feeds the IF/ID register.
// Ports:
//   clk, reset            : clock, asynchronous active-low reset
//   StallF / StallD       : hazard unit freeze of PCF / IF/ID
//   FlushD                : hazard unit bubble into IF/ID
//   PCSrcE / PCTargetE    : execute-stage redirect and its target
//   imem_req / imem_addr  : fetch request and word-aligned address
//   imem_gnt              : request accepted this cycle
//   imem_rvalid/rdata     : response strobe and instruction word
//   InstrD/PCD/PCPlus4D/ValidD : IF/ID contents presented to decode
// ----------------------------------------------------------------------------
module fetch_stage
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          XLEN     = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            StallF,
    input  logic            StallD,
    input  logic            FlushD,
    input  logic            PCSrcE,
    input  logic [XLEN-1:0] PCTargetE,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    output logic [XLEN-1:0] InstrD,
    output logic [XLEN-1:0] PCD,
    output logic [XLEN-1:0] PCPlus4D,
    output logic            ValidD
);

    fetch_state_t r_state;
    logic [31:0]  r_pcf;
    logic [31:0]  r_pc_req;       // PC of the outstanding request
    logic [31:0]  r_hold_instr;
    logic [31:0]  r_hold_pc;
    logic         r_hold_valid;

    logic   w_rsp;        // response for a wanted request arrives
    logic   w_rsp_kill;   // ... but a redirect/flush makes it stale
    logic   w_rsp_park;   // ... and decode is stalled, so park it
    logic   w_rsp_use;    // ... and it goes straight into IF/ID
    logic   w_req;
    logic   w_accept;
    logic   w_load;
    if_id_t w_load_data;
    if_id_t w_if_id;

    assign w_rsp      = (r_state == WAIT) && imem_rvalid;
    assign w_rsp_kill = w_rsp && (PCSrcE || FlushD);
    assign w_rsp_park = w_rsp && !w_rsp_kill && StallD;
    assign w_rsp_use  = w_rsp && !w_rsp_kill && !StallD;

    // A new request may overlap the response cycle, which keeps a 1-cycle
    // memory at full throughput. Gating with reset keeps imem_req low while
    // reset is asserted even though the rest of the term is combinational.
    assign w_req    = reset && !StallF && !PCSrcE && !r_hold_valid &&
                      ((r_state == IDLE) || w_rsp_use);
    assign w_accept = w_req && imem_gnt;

    assign imem_req  = w_req;
    assign imem_addr = word_align(r_pcf);

    // Request tracker
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) r_state <= WAIT;
                end
                WAIT: begin
                    if (imem_rvalid) r_state <= w_accept ? WAIT : IDLE;
                    else if (PCSrcE) r_state <= DROP;
                end
                DROP: begin
                    if (imem_rvalid) r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // PCF: redirect > stall > accepted request > hold
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pcf    <= RESET_PC;
            r_pc_req <= 32'h0;
        end else begin
            if (PCSrcE) begin
                r_pcf <= word_align(PCTargetE);
            end else if (!StallF && w_accept) begin
                r_pcf <= word_align(r_pcf) + 32'd4;
            end
            if (w_accept) begin
                r_pc_req <= word_align(r_pcf);
            end
        end
    end

    // Hold buffer valid flag: a redirect makes any parked word stale
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_hold_valid <= 1'b0;
        end else if (PCSrcE) begin
            r_hold_valid <= 1'b0;
        end else if (w_rsp_park) begin
            r_hold_valid <= 1'b1;
        end else if (r_hold_valid && !FlushD && !StallD) begin
            r_hold_valid <= 1'b0;
        end
    end

    // NOTE: the hold data needs no reset; it is only read while
    // r_hold_valid is set, and that flag is reset.
    always_ff @(posedge clk) begin
        if (w_rsp_park) begin
            r_hold_instr <= imem_rdata;
            r_hold_pc    <= r_pc_req;
        end
    end

    // NOTE: default assignment first so no path leaves w_load_data
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        w_load      = 1'b0;
        w_load_data = IF_ID_BUBBLE;
        if (r_hold_valid) begin
            w_load      = 1'b1;
            w_load_data = '{instr: r_hold_instr, pc: r_hold_pc,
                            pcplus4: r_hold_pc + 32'd4, valid: 1'b1};
        end else if (w_rsp_use) begin
            w_load      = 1'b1;
            w_load_data = '{instr: imem_rdata, pc: r_pc_req,
                            pcplus4: r_pc_req + 32'd4, valid: 1'b1};
        end
    end

    if_id_reg u_if_id_reg (
        .clk     (clk),
        .reset   (reset),
        .i_stall (StallD),
        .i_flush (FlushD),
        .i_load  (w_load),
        .i_data  (w_load_data),
        .o_data  (w_if_id)
    );

    assign InstrD   = w_if_id.instr;
    assign PCD      = w_if_id.pc;
    assign PCPlus4D = w_if_id.pcplus4;
    assign ValidD   = w_if_id.valid;

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;
    import riscv_pkg::*;

    logic        clk;
    logic        reset;
    logic        StallF, StallD, FlushD, PCSrcE;
    logic [31:0] PCTargetE;
    logic        imem_req, imem_gnt, imem_rvalid;
    logic [31:0] imem_addr, imem_rdata;
    logic [31:0] InstrD, PCD, PCPlus4D;
    logic        ValidD;

    int n_vec = 0;
    int n_err = 0;

    // memory model controls
    logic        gnt_en;
    int          lat;
    logic        m_pend;
    int          m_cnt;
    logic [31:0] m_addr;

    fetch_stage #(.RESET_PC(32'h0000_0000), .XLEN(32)) dut (
        .clk(clk), .reset(reset),
        .StallF(StallF), .StallD(StallD), .FlushD(FlushD),
        .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D), .ValidD(ValidD)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0: return 32'h0050_0093;
            32'h4: return 32'h0010_0113;
            default: return {a[19:0], 12'h013};
        endcase
    endfunction

    // Memory: gnt under bench control, response after 'lat' extra cycles
    assign imem_gnt    = gnt_en;
    assign imem_rvalid = m_pend && (m_cnt == 0);
    assign imem_rdata  = mem_word(m_addr);

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_pend <= 1'b0;
            m_cnt  <= 0;
            m_addr <= 32'h0;
        end else if (imem_req && imem_gnt) begin
            m_pend <= 1'b1;
            m_cnt  <= lat;
            m_addr <= imem_addr;
        end else if (m_pend) begin
            if (m_cnt == 0) m_pend <= 1'b0;
            else            m_cnt  <= m_cnt - 1;
        end
    end

    task automatic step();
        @(negedge clk);
    endtask

    // Quiesce, then redirect PCF to target while nothing is outstanding.
    task automatic setup(input logic [31:0] target);
        StallF = 1'b1; StallD = 1'b0; FlushD = 1'b0; PCSrcE = 1'b0;
        repeat (3) step();
        PCSrcE = 1'b1; PCTargetE = target;
        step();
        PCSrcE = 1'b0; StallF = 1'b0;
    endtask

    task automatic test_reset();
        step(); #1;
        n_vec++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL rst_req: got %h exp 0", imem_req); end
        n_vec++; if (imem_addr !== 32'h0) begin n_err++; $display("FAIL rst_addr: got %h exp 0", imem_addr); end
        n_vec++; if (InstrD !== 32'h0000_0013) begin n_err++; $display("FAIL rst_instr: got %h exp 00000013", InstrD); end
        n_vec++; if (PCD !== 32'h0) begin n_err++; $display("FAIL rst_pcd: got %h exp 0", PCD); end
        n_vec++; if (PCPlus4D !== 32'h0) begin n_err++; $display("FAIL rst_pcp4: got %h exp 0", PCPlus4D); end
        n_vec++; if (ValidD !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %h exp 0", ValidD); end
    endtask

    task automatic test_basic();
        reset = 1'b1; gnt_en = 1'b1; lat = 0; #1;
        n_vec++; if (imem_req !== 1'b1) begin n_err++; $display("FAIL basic_req0: got %h exp 1", imem_req); end
        n_vec++; if (imem_addr !== 32'h0) begin n_err++; $display("FAIL basic_addr0: got %h exp 0", imem_addr); end
        step(); #1;
        n_vec++; if (imem_addr !== 32'h4) begin n_err++; $display("FAIL basic_addr1: got %h exp 4", imem_addr); end
        n_vec++; if (ValidD !== 1'b0) begin n_err++; $display("FAIL basic_lat: got %h exp 0", ValidD); end
        step(); #1;
        n_vec++; if (InstrD !== 32'h0050_0093) begin n_err++; $display("FAIL basic_i0: got %h exp 00500093", InstrD); end
        n_vec++; if (PCD !== 32'h0) begin n_err++; $display("FAIL basic_pc0: got %h exp 0", PCD); end
        n_vec++; if (ValidD !== 1'b1) begin n_err++; $display("FAIL basic_v0: got %h exp 1", ValidD); end
        step(); #1;
        n_vec++; if (InstrD !== 32'h0010_0113) begin n_err++; $display("FAIL basic_i1: got %h exp 00100113", InstrD); end
        n_vec++; if (PCD !== 32'h4) begin n_err++; $display("FAIL basic_pc1: got %h exp 4", PCD); end
        n_vec++; if (PCPlus4D !== 32'h8) begin n_err++; $display("FAIL basic_pcp4_1: got %h exp 8", PCPlus4D); end
        n_vec++; if (ValidD !== 1'b1) begin n_err++; $display("FAIL basic_v1: got %h exp 1", ValidD); end
    endtask

    // Response for PC 0x8 is in flight now; stall decode for 3 cycles.
    task automatic test_stall_d();
        StallD = 1'b1; #1;
        n_vec++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL stall_req_rsp: got %h exp 0", imem_req); end
        for (int k = 0; k < 2; k++) begin
            step(); #1;
            n_vec++; if (InstrD !== 32'h0010_0113) begin n_err++; $display("FAIL stall_instr%0d: got %h exp 00100113", k, InstrD); end
            n_vec++; if (PCD !== 32'h4) begin n_err++; $display("FAIL stall_pcd%0d: got %h exp 4", k, PCD); end
            n_vec++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL stall_req%0d: got %h exp 0", k, imem_req); end
            n_vec++; if (dut.r_hold_valid !== 1'b1) begin n_err++; $display("FAIL stall_hold%0d: got %h exp 1", k, dut.r_hold_valid); end
        end
        step(); StallD = 1'b0; #1;
        n_vec++; if (InstrD !== 32'h0010_0113) begin n_err++; $display("FAIL stall_last: got %h exp 00100113", InstrD); end
        n_vec++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL stall_rel_req: got %h exp 0", imem_req); end
        step(); #1;
        n_vec++; if (InstrD !== 32'h0000_8013) begin n_err++; $display("FAIL held_instr: got %h exp 00008013", InstrD); end
        n_vec++; if (PCD !== 32'h8) begin n_err++; $display("FAIL held_pcd: got %h exp 8", PCD); end
        n_vec++; if (PCPlus4D !== 32'hC) begin n_err++; $display("FAIL held_pcp4: got %h exp c", PCPlus4D); end
        n_vec++; if (ValidD !== 1'b1) begin n_err++; $display("FAIL held_valid: got %h exp 1", ValidD); end
        n_vec++; if (imem_addr !== 32'hC) begin n_err++; $display("FAIL held_next_addr: got %h exp c", imem_addr); end
        n_vec++; if (dut.r_hold_valid !== 1'b0) begin n_err++; $display("FAIL held_clear: got %h exp 0", dut.r_hold_valid); end
        step(); #1;
        n_vec++; if (imem_addr !== 32'h10) begin n_err++; $display("FAIL after_hold_addr: got %h exp 10", imem_addr); end
        step(); #1;
        n_vec++; if (InstrD !== 32'h0000_C013) begin n_err++; $display("FAIL after_hold_instr: got %h exp 0000c013", InstrD); end
        n_vec++; if (PCD !== 32'hC) begin n_err++; $display("FAIL after_hold_pcd: got %h exp c", PCD); end
    endtask

    task automatic test_redirect_wait();
        setup(32'h10); lat = 2; #1;
        n_vec++; if (imem_addr !== 32'h10) begin n_err++; $display("FAIL redir_addr: got %h exp 10", imem_addr); end
        step(); PCSrcE = 1'b1; PCTargetE = 32'h40; #1;
        n_vec++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL redir_req: got %h exp 0", imem_req); end
        step(); PCSrcE = 1'b0; #1;
        n_vec++; if (dut.r_state !== DROP) begin n_err++; $display("FAIL redir_state: got %0d exp DROP", dut.r_state); end
        step(); #1;
        n_vec++; if (imem_rvalid !== 1'b1) begin n_err++; $display("FAIL redir_rvalid: got %h exp 1", imem_rvalid); end
        n_vec++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL redir_drop_req: got %h exp 0", imem_req); end
        step(); lat = 0; #1;
        n_vec++; if (ValidD !== 1'b0) begin n_err++; $display("FAIL redir_discard: got %h exp 0", ValidD); end
        n_vec++; if (imem_req !== 1'b1) begin n_err++; $display("FAIL redir_req40: got %h exp 1", imem_req); end
        n_vec++; if (imem_addr !== 32'h40) begin n_err++; $display("FAIL redir_addr40: got %h exp 40", imem_addr); end
        step(); step(); #1;
        n_vec++; if (InstrD !== 32'h0004_0013) begin n_err++; $display("FAIL redir_instr40: got %h exp 00040013", InstrD); end
        n_vec++; if (PCD !== 32'h40) begin n_err++; $display("FAIL redir_pcd40: got %h exp 40", PCD); end
    endtask

    task automatic test_flush_rsp();
        setup(32'h1C); #1;
        step(); step();
        PCSrcE = 1'b1; FlushD = 1'b1; PCTargetE = 32'h40; #1;
        n_vec++; if (ValidD !== 1'b1) begin n_err++; $display("FAIL flush_pre_valid: got %h exp 1", ValidD); end
        n_vec++; if (imem_rvalid !== 1'b1) begin n_err++; $display("FAIL flush_rvalid: got %h exp 1", imem_rvalid); end
        step(); PCSrcE = 1'b0; FlushD = 1'b0; #1;
        n_vec++; if (InstrD !== 32'h0000_0013) begin n_err++; $display("FAIL flush_instr: got %h exp 00000013", InstrD); end
        n_vec++; if (ValidD !== 1'b0) begin n_err++; $display("FAIL flush_valid: got %h exp 0", ValidD); end
        n_vec++; if (PCD !== 32'h0) begin n_err++; $display("FAIL flush_pcd: got %h exp 0", PCD); end
        n_vec++; if (dut.r_state !== IDLE) begin n_err++; $display("FAIL flush_state: got %0d exp IDLE", dut.r_state); end
        n_vec++; if (imem_addr !== 32'h40) begin n_err++; $display("FAIL flush_addr: got %h exp 40", imem_addr); end
    endtask

    task automatic test_gnt_wait();
        gnt_en = 1'b0;
        setup(32'h50);
        for (int k = 0; k < 4; k++) begin
            #1;
            n_vec++; if (imem_req !== 1'b1) begin n_err++; $display("FAIL nogrant_req%0d: got %h exp 1", k, imem_req); end
            n_vec++; if (imem_addr !== 32'h50) begin n_err++; $display("FAIL nogrant_addr%0d: got %h exp 50", k, imem_addr); end
            n_vec++; if (dut.r_pcf !== 32'h50) begin n_err++; $display("FAIL nogrant_pcf%0d: got %h exp 50", k, dut.r_pcf); end
            step();
        end
        gnt_en = 1'b1;
        step(); #1;
        n_vec++; if (imem_addr !== 32'h54) begin n_err++; $display("FAIL grant_next: got %h exp 54", imem_addr); end
        step(); #1;
        n_vec++; if (InstrD !== 32'h0005_0013) begin n_err++; $display("FAIL grant_instr: got %h exp 00050013", InstrD); end
    endtask

    task automatic test_wrap_reset();
        setup(32'hFFFF_FFFC); #1;
        n_vec++; if (imem_addr !== 32'hFFFF_FFFC) begin n_err++; $display("FAIL wrap_addr: got %h exp fffffffc", imem_addr); end
        step(); #1;
        n_vec++; if (imem_addr !== 32'h0) begin n_err++; $display("FAIL wrap_next: got %h exp 0", imem_addr); end
        step(); #1;
        n_vec++; if (InstrD !== 32'hFFFF_C013) begin n_err++; $display("FAIL wrap_instr: got %h exp ffffc013", InstrD); end
        n_vec++; if (PCD !== 32'hFFFF_FFFC) begin n_err++; $display("FAIL wrap_pcd: got %h exp fffffffc", PCD); end
        n_vec++; if (PCPlus4D !== 32'h0) begin n_err++; $display("FAIL wrap_pcp4: got %h exp 0", PCPlus4D); end
        n_vec++; if (dut.r_state !== WAIT) begin n_err++; $display("FAIL wrap_state: got %0d exp WAIT", dut.r_state); end
        #1 reset = 1'b0; #1;
        n_vec++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL arst_req: got %h exp 0", imem_req); end
        n_vec++; if (imem_addr !== 32'h0) begin n_err++; $display("FAIL arst_addr: got %h exp 0", imem_addr); end
        n_vec++; if (InstrD !== 32'h0000_0013) begin n_err++; $display("FAIL arst_instr: got %h exp 00000013", InstrD); end
        n_vec++; if (PCD !== 32'h0) begin n_err++; $display("FAIL arst_pcd: got %h exp 0", PCD); end
        n_vec++; if (ValidD !== 1'b0) begin n_err++; $display("FAIL arst_valid: got %h exp 0", ValidD); end
        n_vec++; if (dut.r_state !== IDLE) begin n_err++; $display("FAIL arst_state: got %0d exp IDLE", dut.r_state); end
        repeat (2) step();
    endtask

    initial begin
        reset = 1'b0; StallF = 1'b0; StallD = 1'b0; FlushD = 1'b0;
        PCSrcE = 1'b0; PCTargetE = 32'h0; gnt_en = 1'b0; lat = 0;
        test_reset();
        test_basic();
        test_stall_d();
        test_redirect_wait();
        test_flush_rsp();
        test_gnt_wait();
        test_wrap_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout exp completion");
        $fatal(1, "watchdog expired");
    end

endmodule
